// File: rtl/periph_reg_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// periph_reg_arbiter : round-robin host/DMA access to a bank of peripheral regs
// Rev 1.0
// ----------------------------------------------------------------------------
module periph_reg_arbiter #(
  parameter int REGS         = 3,
  parameter int ADDRESSWIDTH = $clog2(REGS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [ADDRESSWIDTH-1:0] addr0,
  input  logic [ADDRESSWIDTH-1:0] addr1,
  input  logic [31:0]             wdata0,
  input  logic [31:0]             wdata1,
  output logic [1:0]              ack,
  output logic [31:0]             rdata,
  output logic                    err,
  output logic [REGS-1:0]         p_write_en,
  output logic [31:0]             p_data_in,
  input  logic [REGS*32-1:0]      p_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [ADDRESSWIDTH:0] REGS_W = (ADDRESSWIDTH+1)'(REGS);

  state_t                  state;
  state_t                  state_nxt;
  logic                    last_grant;
  logic                    grant_nxt;
  logic                    lat_id;
  logic                    lat_we;
  logic [ADDRESSWIDTH-1:0] lat_addr;
  logic [31:0]             lat_wdata;
  logic                    in_range;
  logic                    wr_access;
  logic [31:0]             rd_mux;

  // Host wins a tie after reset because last_grant resets to the DMA side.
  always_comb begin
    grant_nxt = 1'b0;
    case (req)
      2'b01:   grant_nxt = 1'b0;
      2'b10:   grant_nxt = 1'b1;
      2'b11:   grant_nxt = ~last_grant;
      default: grant_nxt = 1'b0;
    endcase
  end

  assign in_range  = {1'b0, lat_addr} < REGS_W;
  assign wr_access = (state == ACCESS) && lat_we;
  assign p_data_in = wr_access ? lat_wdata : 32'd0;

  // Per-bit address decode keeps the strobe one-hot and silent when out of range.
  for (genvar k = 0; k < REGS; k++) begin : g_strobe
    assign p_write_en[k] = wr_access && (lat_addr == ADDRESSWIDTH'(k));
  end

  always_comb begin
    rd_mux = 32'd0;
    for (int k = 0; k < REGS; k++) begin
      if (lat_addr == ADDRESSWIDTH'(k)) rd_mux = p_data_out[32*k +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack       = 2'b00;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) state_nxt = ACCESS;
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        state_nxt   = IDLE;
        ack[lat_id] = 1'b1;
        err         = ~in_range;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= 32'd0;
      rdata      <= 32'd0;
    end else begin
      if (state == IDLE && req != 2'b00) begin
        last_grant <= grant_nxt;
        lat_id     <= grant_nxt;
        lat_we     <= we[grant_nxt];
        lat_addr   <= grant_nxt ? addr1 : addr0;
        lat_wdata  <= grant_nxt ? wdata1 : wdata0;
      end
      // Reads capture the register; any out-of-range access returns zero.
      if (state == ACCESS && (!lat_we || !in_range)) rdata <= rd_mux;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_periph_reg_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_periph_reg_arbiter : directed scenarios plus randomized model comparison
// ----------------------------------------------------------------------------
module tb_periph_reg_arbiter;

  localparam int REGS = 3;
  localparam int AW   = 2;

  logic              clk;
  logic              reset_n;
  logic [1:0]        req;
  logic [1:0]        we;
  logic [AW-1:0]     addr0;
  logic [AW-1:0]     addr1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic [1:0]        ack;
  logic [31:0]       rdata;
  logic              err;
  logic [REGS-1:0]   p_write_en;
  logic [31:0]       p_data_in;
  logic [REGS*32-1:0] p_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  periph_reg_arbiter #(.REGS(REGS), .ADDRESSWIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .p_write_en(p_write_en),
    .p_data_in (p_data_in),
    .p_data_out(p_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0; req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0;
    wdata0 = 32'd0; wdata1 = 32'd0; p_data_out = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", ack); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_checks++; if (p_write_en !== 3'b000) begin n_fail++; $display("FAIL reset_wen: got %b want 000", p_write_en); end
    n_checks++; if (p_data_in !== 32'd0) begin n_fail++; $display("FAIL reset_pdin: got %h want 0", p_data_in); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL idle_ack: got %b want 00", ack); end
  endtask

  task automatic test_host_write();
    req = 2'b01; we = 2'b01; addr0 = 2'd0; wdata0 = 32'h0000_1234;
    @(negedge clk);
    req = 2'b00;
    n_checks++; if (p_write_en !== 3'b001) begin n_fail++; $display("FAIL hw_wen: got %b want 001", p_write_en); end
    n_checks++; if (p_data_in !== 32'h0000_1234) begin n_fail++; $display("FAIL hw_pdin: got %h want 00001234", p_data_in); end
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL hw_early_ack: got %b want 00", ack); end
    @(negedge clk);
    n_checks++; if (p_write_en !== 3'b000) begin n_fail++; $display("FAIL hw_wen_drop: got %b want 000", p_write_en); end
    n_checks++; if (p_data_in !== 32'd0) begin n_fail++; $display("FAIL hw_pdin_drop: got %h want 0", p_data_in); end
    n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL hw_ack: got %b want 01", ack); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL hw_err: got %b want 0", err); end
    @(negedge clk);
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL hw_ack_pulse: got %b want 00", ack); end
  endtask

  task automatic test_dma_read();
    p_data_out[2*32 +: 32] = 32'h0000_0001;
    req = 2'b10; we = 2'b00; addr1 = 2'd2;
    @(negedge clk);
    req = 2'b00;
    n_checks++; if (p_write_en !== 3'b000) begin n_fail++; $display("FAIL dr_wen: got %b want 000", p_write_en); end
    @(negedge clk);
    n_checks++; if (ack !== 2'b10) begin n_fail++; $display("FAIL dr_ack: got %b want 10", ack); end
    n_checks++; if (rdata !== 32'h0000_0001) begin n_fail++; $display("FAIL dr_rdata: got %h want 00000001", rdata); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL dr_err: got %b want 0", err); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    reset_n = 1'b0; req = 2'b11; we = 2'b00; addr0 = 2'd0; addr1 = 2'd1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp = 2'b00;
      if (i % 3 == 2) exp = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if (ack !== exp) begin n_fail++; $display("FAIL contention_ack cycle %0d: got %b want %b", i, ack, exp); end
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    p_data_out[1*32 +: 32] = 32'hA5A5_0001;
    req = 2'b01; we = 2'b00; addr0 = 2'd1;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    n_checks++; if (rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL oor_pre_rdata: got %h want a5a50001", rdata); end
    @(negedge clk);
    req = 2'b01; we = 2'b01; addr0 = 2'd3; wdata0 = 32'hDEAD_BEEF;
    @(negedge clk);
    req = 2'b00;
    n_checks++; if (p_write_en !== 3'b000) begin n_fail++; $display("FAIL oor_wen: got %b want 000", p_write_en); end
    @(negedge clk);
    n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL oor_ack: got %b want 01", ack); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", err); end
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL oor_rdata: got %h want 0", rdata); end
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear: got %b want 0", err); end
  endtask

  task automatic test_reset_in_access();
    req = 2'b01; we = 2'b01; addr0 = 2'd1; wdata0 = 32'h1111_2222;
    @(negedge clk);
    n_checks++; if (p_write_en !== 3'b010) begin n_fail++; $display("FAIL ria_wen: got %b want 010", p_write_en); end
    reset_n = 1'b0; req = 2'b11; we = 2'b01; addr0 = 2'd2; addr1 = 2'd0;
    @(negedge clk);
    n_checks++; if (p_write_en !== 3'b000) begin n_fail++; $display("FAIL ria_wen_abort: got %b want 000", p_write_en); end
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL ria_no_ack: got %b want 00", ack); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (p_write_en !== 3'b100) begin n_fail++; $display("FAIL ria_host_first: got %b want 100", p_write_en); end
    req = 2'b00;
    @(negedge clk);
    n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL ria_ack: got %b want 01", ack); end
    @(negedge clk);
  endtask

  task automatic test_req_change();
    p_data_out[0*32 +: 32] = 32'h0BAD_0000;
    p_data_out[1*32 +: 32] = 32'h600D_0001;
    req = 2'b01; we = 2'b00; addr0 = 2'd1;
    @(negedge clk);
    req = 2'b00; addr0 = 2'd0; we = 2'b01;
    @(negedge clk);
    n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL rc_ack: got %b want 01", ack); end
    n_checks++; if (rdata !== 32'h600D_0001) begin n_fail++; $display("FAIL rc_rdata: got %h want 600d0001", rdata); end
    @(negedge clk);
  endtask

  // Transaction-level reference: a grant at cycle tg yields the strobe at tg+1 and the ack at tg+2.
  task automatic test_random();
    int         tg, t_id, t_addr, last, c;
    logic       t_we;
    logic [31:0] t_wdata, m_rdata, e_din;
    logic [2:0] e_wen;
    logic [1:0] e_ack;
    logic       e_err, chk_din;
    reset_n = 1'b0; req = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tg = -10; t_id = 0; t_addr = 0; t_we = 1'b0; t_wdata = 32'd0;
    last = 1; m_rdata = 32'd0;
    for (c = 0; c < 400; c++) begin
      e_wen = 3'b000; e_din = 32'd0; e_ack = 2'b00; e_err = 1'b0; chk_din = 1'b1;
      if (c == tg + 1 && t_we) begin
        if (t_addr < REGS) begin
          e_wen = 3'b001 << t_addr;
          e_din = t_wdata;
        end else begin
          chk_din = 1'b0;
        end
      end
      if (c == tg + 2) begin
        e_ack = 2'b01 << t_id;
        e_err = (t_addr >= REGS);
      end
      n_checks++; if (p_write_en !== e_wen) begin n_fail++; $display("FAIL rnd_wen c%0d: got %b want %b", c, p_write_en, e_wen); end
      if (chk_din) begin
        n_checks++; if (p_data_in !== e_din) begin n_fail++; $display("FAIL rnd_pdin c%0d: got %h want %h", c, p_data_in, e_din); end
      end
      n_checks++; if (ack !== e_ack) begin n_fail++; $display("FAIL rnd_ack c%0d: got %b want %b", c, ack, e_ack); end
      n_checks++; if (err !== e_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, err, e_err); end
      n_checks++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata, m_rdata); end

      req    = 2'($urandom_range(0, 3));
      we     = 2'($urandom_range(0, 3));
      addr0  = 2'($urandom_range(0, 3));
      addr1  = 2'($urandom_range(0, 3));
      wdata0 = $urandom;
      wdata1 = $urandom;
      for (int k = 0; k < REGS; k++) p_data_out[k*32 +: 32] = $urandom;

      if (c == tg + 1) begin
        if (t_addr >= REGS) m_rdata = 32'd0;
        else if (!t_we)     m_rdata = p_data_out[t_addr*32 +: 32];
      end
      if (c >= tg + 3 && req != 2'b00) begin
        if (req == 2'b01)      t_id = 0;
        else if (req == 2'b10) t_id = 1;
        else                   t_id = 1 - last;
        last    = t_id;
        tg      = c;
        t_we    = we[t_id];
        t_addr  = (t_id == 0) ? int'(addr0) : int'(addr1);
        t_wdata = (t_id == 0) ? wdata0 : wdata1;
      end
      @(negedge clk);
    end
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_dma_read();
    test_contention();
    test_out_of_range();
    test_reset_in_access();
    test_req_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/periph_reg_arbiter.md
PERIPH_REG_ARBITER -- requirements
Module: periph_reg_arbiter

Interface
REQ-001 Parameter REGS, default 3: number of peripheral registers.
REQ-002 Parameter ADDRESSWIDTH, default $clog2(REGS): requester address width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  2  per-requester access request (bit 0 = host, bit 1 = dma).
REQ-006 we  input  2  per-requester direction: 1 = write, 0 = read.
REQ-007 addr0, addr1  input  ADDRESSWIDTH each  register index per requester.
REQ-008 wdata0, wdata1  input  32 each  write data per requester.
REQ-009 ack  output  2  one-cycle completion pulse to the served requester.
REQ-010 rdata  output  32  read data, valid only while ack is nonzero.
REQ-011 err  output  1  out-of-range access flag, valid only while ack is nonzero.
REQ-012 p_write_en  output  REGS  one-hot register write strobe to the peripheral.
REQ-013 p_data_in  output  32  write data to the peripheral.
REQ-014 p_data_out  input  REGS*32  flattened peripheral register read values; register k occupies bits [32k+31:32k].

Function
REQ-015 The block SHALL implement the three-state FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-016 In IDLE with req nonzero, the block SHALL grant one requester and latch its we, addr and wdata, then enter ACCESS.
REQ-017 Arbitration SHALL be round-robin, using a last_grant register as follows:
- single requester: always granted;
- both requesting: the requester != last_grant is granted;
- last_grant is updated on every grant.
REQ-018 Requests SHALL be ignored in ACCESS and RESP; input changes after the grant SHALL NOT affect the latched transaction.
REQ-019 In ACCESS with a latched write and addr < REGS, p_write_en[addr] SHALL be 1 for exactly that one cycle, and p_data_in SHALL equal the latched wdata.
REQ-020 In ACCESS with a latched read and addr < REGS, the block SHALL capture p_data_out[addr] into rdata; p_write_en SHALL stay 0.
REQ-021 If the latched addr >= REGS, the block SHALL raise no strobe, SHALL return rdata = 0, and SHALL set err = 1 in RESP.
REQ-022 In RESP, ack[granted id] SHALL be 1 for one cycle, with rdata and err valid; the other ack bit SHALL be 0.
REQ-023 Outside RESP, the following SHALL hold:
- ack = 0 and err = 0;
- rdata holds its last value;
- p_write_en = 0 and p_data_in = 0 outside a write ACCESS.
REQ-024 Latency SHALL be fixed: req sampled in IDLE at cycle T, strobe/capture at T+1, ack at T+2; maximum throughput is one transaction per 3 cycles.
REQ-025 A requester still holding req in the cycle after its ack SHALL be treated as issuing a new request.
REQ-026 At most one p_write_en bit SHALL ever be 1 in any cycle.

Reset
REQ-027 While reset_n = 0 at a rising edge, the block SHALL load these values:
- state = IDLE;
- ack = 0, err = 0, rdata = 0;
- p_write_en = 0, p_data_in = 0;
- last_grant = 1, so the host has first priority.
REQ-028 Reset asserted mid-transaction SHALL abort it: no ack is issued, and any strobe is deasserted at the next edge.

Verification
REQ-029 Host write: req = 01, we = 01, addr0 = 0, wdata0 = 0x00001234 -> at T+1 p_write_en = 001 and p_data_in = 0x00001234 for one cycle; at T+2 ack = 01 and err = 0.
REQ-030 DMA read: req = 10, addr1 = 2, p_data_out[2] = 0x00000001 -> p_write_en stays 000; at T+2 ack = 10 and rdata = 0x00000001.
REQ-031 Contention: both req held high from reset release -> acks 01, 10, 01, 10, spaced 3 cycles apart.
REQ-032 Out of range: host write to addr0 = 3 -> p_write_en stays 000; ack = 01, err = 1, rdata = 0.
REQ-033 Reset in ACCESS: reset_n = 0 during a write strobe -> next cycle p_write_en = 000 with no ack; a subsequent simultaneous request is granted to the host first.
REQ-034 Request change after grant: host read of addr0 = 1 is granted, then addr0 is changed to 0 during ACCESS -> rdata = p_data_out[1].
